// File: rtl/rom_load_pkg.sv
// Shared types and constants for the cartridge image loader.
//   state_e    : loader sequencing states
//   HDR_*_OFS  : offsets of captured fields within the SNES internal header
//   size_mask  : converts a header size code into an address mask
package rom_load_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FLUSH,
    ST_DRAIN,
    ST_DONE,
    ST_FAIL
  } state_e;

  localparam logic [23:0] HDR_MAP_OFS   = 24'h15;
  localparam logic [23:0] HDR_ROMSZ_OFS = 24'h17;
  localparam logic [23:0] HDR_RAMSZ_OFS = 24'h18;

  // Size code n describes 1 KiB << n; large codes shift out and give all ones.
  function automatic logic [23:0] size_mask(input logic [7:0] sz);
    logic [23:0] base;
    base = 24'h400;
    return (base << sz) - 24'd1;
  endfunction

endpackage

// File: rtl/load_word_fifo.sv
// Synchronous first-word-fall-through FIFO holding {address, data} words.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset
//   clr_i   : synchronous discard of all contents
//   push_i  : write wdata_i (dropped when full unless popping same cycle)
//   wdata_i : word to write
//   pop_i   : remove head word (ignored when empty)
//   rdata_o : current head word
//   full_o  : no free entry
//   empty_o : no stored entry
module load_word_fifo #(
  parameter int unsigned WIDTH = 39,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [PW:0]      cnt_q;
  logic             do_push, do_pop;

  always_comb begin
    empty_o = (cnt_q == '0);
    full_o  = (cnt_q == FULL_CNT);
    do_pop  = pop_i & ~empty_o;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    do_push = push_i & (~full_o | do_pop);
    rdata_o = mem_q[rd_q];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/rom_load_ctrl.sv
// Streams a cartridge image byte-by-byte into SDRAM as 16-bit words and
// captures the SNES header fields while the image passes through.
//   wclk, reset        : clock, synchronous active-high reset
//   start              : begin a new load (accepted in IDLE/DONE/FAIL)
//   src_dout/src_valid : image byte and its strobe
//   src_loading        : falling edge marks end of image
//   mem_addr/mem_din   : write address (even) and data, held while mem_req
//   mem_req/mem_ack    : write handshake to the SDRAM arbiter
//   map_ctrl, rom_size : captured header fields; rom_mask/ram_mask derived
//   loading/done/fail  : loader status
module rom_load_ctrl
  import rom_load_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [23:0] HDR_BASE   = 24'h7FC0,
  parameter int unsigned ADDR_W     = 23
) (
  input  logic              wclk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        src_dout,
  input  logic              src_valid,
  input  logic              src_loading,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_din,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [7:0]        map_ctrl,
  output logic [3:0]        rom_size,
  output logic [23:0]       rom_mask,
  output logic [23:0]       ram_mask,
  output logic              loading,
  output logic              done,
  output logic              fail
);

  localparam int unsigned FW = ADDR_W + 16;

  state_e            state_q;
  logic [23:0]       bc_q;
  logic [7:0]        low_q;
  logic              odd_q, ldprev_q;
  logic [7:0]        map_q, ramsz_q;
  logic [3:0]        romsz_q;
  logic              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       din_q;
  logic              loading_q, done_q, fail_q;

  logic              busy, byte_stb, load_end, push, pop, overflow, start_ok, fifo_clr;
  logic              fifo_full, fifo_empty;
  logic [ADDR_W-1:0] push_addr;
  logic [15:0]       push_data;
  logic [FW-1:0]     head_word;

  always_comb begin
    busy     = state_q inside {ST_LOAD, ST_FLUSH, ST_DRAIN};
    byte_stb = (state_q == ST_LOAD) & src_valid;
    load_end = (state_q == ST_LOAD) & ldprev_q & ~src_loading;
    // In both LOAD and FLUSH the word starts one byte before the counter.
    push_addr    = ADDR_W'(bc_q - 24'd1);
    push_addr[0] = 1'b0;
    push_data = (state_q == ST_FLUSH) ? {8'h00, low_q} : {src_dout, low_q};
    push      = odd_q & (byte_stb | (state_q == ST_FLUSH));
    pop       = busy & ~req_q & ~fifo_empty;
    overflow  = push & fifo_full & ~pop;
    start_ok  = start & ~req_q & (state_q inside {ST_IDLE, ST_DONE, ST_FAIL});
    fifo_clr  = start_ok | overflow;
  end

  load_word_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (wclk),
    .rst_i   (reset),
    .clr_i   (fifo_clr),
    .push_i  (push),
    .wdata_i ({push_addr, push_data}),
    .pop_i   (pop),
    .rdata_o (head_word),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge wclk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      bc_q      <= '0;
      low_q     <= '0;
      odd_q     <= 1'b0;
      ldprev_q  <= 1'b0;
      map_q     <= '0;
      romsz_q   <= '0;
      ramsz_q   <= '0;
      req_q     <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      loading_q <= 1'b0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      ldprev_q <= src_loading;

      // Writer: a pop only happens with the bus idle, so it never races an ack.
      if (pop) begin
        req_q  <= 1'b1;
        addr_q <= head_word[FW-1:16];
        din_q  <= head_word[15:0];
      end else if (req_q && mem_ack) begin
        req_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE, ST_DONE, ST_FAIL: begin
          if (start_ok) begin
            state_q   <= ST_LOAD;
            bc_q      <= '0;
            low_q     <= '0;
            odd_q     <= 1'b0;
            map_q     <= '0;
            romsz_q   <= '0;
            ramsz_q   <= '0;
            loading_q <= 1'b1;
            done_q    <= 1'b0;
            fail_q    <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (byte_stb) begin
            if (bc_q != '1) bc_q <= bc_q + 24'd1;
            if (!odd_q) begin
              low_q <= src_dout;
              odd_q <= 1'b1;
            end else begin
              odd_q <= 1'b0;
            end
            if (bc_q == HDR_BASE + HDR_MAP_OFS)   map_q   <= src_dout;
            if (bc_q == HDR_BASE + HDR_ROMSZ_OFS) romsz_q <= src_dout[3:0];
            if (bc_q == HDR_BASE + HDR_RAMSZ_OFS) ramsz_q <= src_dout;
          end
          if (load_end) state_q <= ST_FLUSH;
        end
        ST_FLUSH: begin
          odd_q   <= 1'b0;
          state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (fifo_empty && !req_q) begin
            state_q   <= ST_DONE;
            loading_q <= 1'b0;
            done_q    <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // Overflow overrides whatever LOAD/FLUSH decided this cycle.
      if (overflow) begin
        state_q   <= ST_FAIL;
        loading_q <= 1'b0;
        fail_q    <= 1'b1;
      end
    end
  end

  assign mem_req  = req_q;
  assign mem_addr = addr_q;
  assign mem_din  = din_q;
  assign map_ctrl = map_q;
  assign rom_size = romsz_q;
  assign rom_mask = size_mask({4'h0, romsz_q});
  assign ram_mask = size_mask(ramsz_q);
  assign loading  = loading_q;
  assign done     = done_q;
  assign fail     = fail_q;

endmodule

// File: tb/tb_rom_load_ctrl.sv
module tb_rom_load_ctrl;

  logic        wclk = 1'b0;
  logic        reset, start, src_valid, src_loading, mem_ack, mem_req;
  logic        loading, done, fail;
  logic [7:0]  src_dout, map_ctrl;
  logic [22:0] mem_addr;
  logic [15:0] mem_din;
  logic [3:0]  rom_size;
  logic [23:0] rom_mask, ram_mask;

  int checks = 0;
  int errors = 0;

  int ack_delay = 1;
  bit ack_en = 1'b1;
  int ack_cnt = 0;
  int req_rises = 0;
  logic [22:0] log_addr[$];
  logic [15:0] log_din[$];

  always #5 wclk = ~wclk;

  rom_load_ctrl dut (
    .wclk        (wclk),
    .reset       (reset),
    .start       (start),
    .src_dout    (src_dout),
    .src_valid   (src_valid),
    .src_loading (src_loading),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .mem_req     (mem_req),
    .mem_ack     (mem_ack),
    .map_ctrl    (map_ctrl),
    .rom_size    (rom_size),
    .rom_mask    (rom_mask),
    .ram_mask    (ram_mask),
    .loading     (loading),
    .done        (done),
    .fail        (fail)
  );

  // SDRAM arbiter model: acks ack_delay cycles after mem_req is seen high.
  initial begin
    int   wait_cnt;
    logic prev_req;
    mem_ack  = 1'b0;
    wait_cnt = 0;
    prev_req = 1'b0;
    forever begin
      @(posedge wclk);
      #1;
      mem_ack = 1'b0;
      if (mem_req && !prev_req) req_rises++;
      prev_req = mem_req;
      if (mem_req && ack_en) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack = 1'b1;
          ack_cnt++;
          log_addr.push_back(mem_addr);
          log_din.push_back(mem_din);
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge wclk);
  endtask

  task automatic pulse_start();
    @(negedge wclk) start = 1'b1;
    @(negedge wclk) start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge wclk);
    src_dout  = b;
    src_valid = 1'b1;
    @(negedge wclk);
    src_valid = 1'b0;
  endtask

  task automatic end_image();
    @(negedge wclk) src_loading = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int n;
    n = 0;
    while (!done && !fail && n < max) begin
      @(negedge wclk);
      n++;
    end
    chk(tag, 32'(done), 1);
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_din.delete();
  endtask

  task automatic check_write(input string tag, input int idx, input logic [22:0] a,
                             input logic [15:0] d);
    if (idx < log_addr.size()) begin
      chk({tag, "_addr"}, 32'(log_addr[idx]), 32'(a));
      chk({tag, "_din"}, 32'(log_din[idx]), 32'(d));
    end else begin
      chk({tag, "_present"}, 32'(log_addr.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    logic [7:0] b;
    int         a0, r0, n;

    reset = 1'b1; start = 1'b0; src_valid = 1'b0; src_dout = '0; src_loading = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);

    // Reset state
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_din", 32'(mem_din), 0);
    chk("rst_map", 32'(map_ctrl), 0);
    chk("rst_romsz", 32'(rom_size), 0);
    chk("rst_rommask", 32'(rom_mask), 'h3FF);
    chk("rst_rammask", 32'(ram_mask), 'h3FF);
    chk("rst_loading", 32'(loading), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_fail", 32'(fail), 0);

    // Even-length stream, plus first-word latency
    clear_log();
    ack_delay = 1;
    src_loading = 1'b1;
    pulse_start();
    chk("t1_loading", 32'(loading), 1);
    send_byte(8'h11);
    send_byte(8'h22);
    chk("t1_lat_t1", 32'(mem_req), 0);
    @(negedge wclk);
    chk("t1_lat_t2", 32'(mem_req), 1);
    send_byte(8'h33);
    send_byte(8'h44);
    end_image();
    wait_done("t1_done", 100);
    chk("t1_nwr", 32'(log_addr.size()), 2);
    check_write("t1_w0", 0, 23'h0, 16'h2211);
    check_write("t1_w1", 1, 23'h2, 16'h4433);
    chk("t1_fail", 32'(fail), 0);
    chk("t1_loading_end", 32'(loading), 0);

    // Odd-length stream flushes a zero-padded final word
    clear_log();
    src_loading = 1'b1;
    pulse_start();
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    end_image();
    wait_done("t2_done", 100);
    chk("t2_nwr", 32'(log_addr.size()), 2);
    check_write("t2_w0", 0, 23'h0, 16'hBBAA);
    check_write("t2_w1", 1, 23'h2, 16'h00CC);
    // Bytes outside LOAD are ignored
    send_byte(8'h77);
    tick(4);
    chk("t2_ignored_nwr", 32'(log_addr.size()), 2);
    chk("t2_ignored_req", 32'(mem_req), 0);
    chk("t2_ignored_done", 32'(done), 1);

    // Header capture from a full LoROM header region
    clear_log();
    ack_delay = 0;
    src_loading = 1'b1;
    pulse_start();
    for (int i = 0; i < 32729; i++) begin
      b = 8'(i);
      if (i == 'h7FD5) b = 8'h21;
      if (i == 'h7FD7) b = 8'h0A;
      if (i == 'h7FD8) b = 8'h03;
      send_byte(b);
    end
    end_image();
    wait_done("t3_done", 200);
    chk("t3_map", 32'(map_ctrl), 'h21);
    chk("t3_romsz", 32'(rom_size), 'hA);
    chk("t3_rommask", 32'(rom_mask), 'h0FFFFF);
    chk("t3_rammask", 32'(ram_mask), 'h001FFF);
    chk("t3_nwr", 32'(log_addr.size()), 16365);
    check_write("t3_hdr_map", 'h3FEA, 23'h7FD4, 16'h21D4);
    check_write("t3_hdr_rom", 'h3FEB, 23'h7FD6, 16'h0AD6);
    check_write("t3_last", 16364, 23'h7FD8, 16'h0003);

    // Overflow: slow acks let the FIFO fill
    clear_log();
    ack_delay = 40;
    src_loading = 1'b1;
    pulse_start();
    chk("t4_map_cleared", 32'(map_ctrl), 0);
    chk("t4_rommask_cleared", 32'(rom_mask), 'h3FF);
    for (int i = 0; i < 16; i++) send_byte(8'h40 + 8'(i));
    chk("t4_fail", 32'(fail), 1);
    chk("t4_loading", 32'(loading), 0);
    chk("t4_done", 32'(done), 0);
    chk("t4_req_outstanding", 32'(mem_req), 1);
    a0 = ack_cnt;
    r0 = req_rises;
    tick(80);
    chk("t4_acks_after_fail", 32'(ack_cnt - a0), 1);
    chk("t4_new_reqs", 32'(req_rises - r0), 0);
    chk("t4_req_low", 32'(mem_req), 0);
    chk("t4_fail_sticky", 32'(fail), 1);
    check_write("t4_w0", 0, 23'h0, 16'h4140);
    end_image();

    // Reset while a request is outstanding
    clear_log();
    ack_en = 1'b0;
    ack_delay = 1;
    src_loading = 1'b1;
    pulse_start();
    send_byte(8'h11);
    send_byte(8'h22);
    n = 0;
    while (!mem_req && n < 10) begin
      @(negedge wclk);
      n++;
    end
    chk("t5_req_before_reset", 32'(mem_req), 1);
    reset = 1'b1;
    @(negedge wclk);
    chk("t5_req", 32'(mem_req), 0);
    chk("t5_addr", 32'(mem_addr), 0);
    chk("t5_din", 32'(mem_din), 0);
    chk("t5_loading", 32'(loading), 0);
    chk("t5_done", 32'(done), 0);
    chk("t5_fail", 32'(fail), 0);
    reset = 1'b0;
    ack_en = 1'b1;
    tick(1);
    pulse_start();
    send_byte(8'h5A);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h02);
    end_image();
    wait_done("t5_done", 100);
    chk("t5_nwr", 32'(log_addr.size()), 2);
    check_write("t5_w0", 0, 23'h0, 16'hA55A);
    check_write("t5_w1", 1, 23'h2, 16'h0201);

    // Ack lands so the pop coincides with a push while three words are queued
    clear_log();
    ack_delay = 13;
    src_loading = 1'b1;
    pulse_start();
    for (int j = 0; j < 12; j++) begin
      send_byte(8'h10 + 8'(j));
      if (j == 9) ack_delay = 1;
    end
    end_image();
    wait_done("t6_done", 200);
    chk("t6_fail", 32'(fail), 0);
    chk("t6_nwr", 32'(log_addr.size()), 6);
    for (int k = 0; k < 6; k++) begin
      check_write($sformatf("t6_w%0d", k), k, 23'(2 * k),
                  {8'h11 + 8'(2 * k), 8'h10 + 8'(2 * k)});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
